imm_gen_stage: RTL and testbench
================================

// Module: imm_gen_stage
// PURPOSE
//  Registered immediate-generation stage between fetch and decode/execute. Extracts the immediate for every
//  RV32I/RV64I format, plus the PC-relative target for B/J/AUIPC, and classifies the instruction format.
//  Valid/ready handshake on both sides, flush for redirects, saturating illegal-instruction counter.
// PARAMETERS
//  XLEN   32  datapath width; 32 or 64 (any other value: elaboration error)
//  CNT_W  16  width of the illegal-instruction counter
// PORTS
//  clk          in   1       clock
//  reset        in   1       synchronous, active-high reset
//  flush        in   1       drop the held output and any input accepted this cycle
//  in_valid     in   1       inst_code/pc valid
//  in_ready     out  1       stage can accept this cycle
//  inst_code    in   32      instruction word
//  pc           in   XLEN    address of inst_code
//  out_valid    out  1       output registers hold a result
//  out_ready    in   1       consumer takes the result
//  imm_out      out  XLEN    immediate
//  target_out   out  XLEN    pc+imm for fmt B/J/AUIPC, else 0
//  fmt_out      out  3       0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SYS, 7 ILLEGAL
//  illegal_out  out  1       fmt_out==7
//  illegal_cnt  out  CNT_W   count of accepted illegal instructions
// BEHAVIOUR
//  Reset: every output register, including illegal_cnt, is 0; out_valid=0. in_ready is combinational.
//  in_ready = !out_valid | out_ready | flush.
//  accept = in_valid & in_ready & !flush.
//  Latency: 1 cycle. A word accepted at edge N is presented from edge N+1.
//  Output registers load only on accept and hold stable while out_valid & !out_ready.
//  out_valid next-state:
//    reset or flush  -> 0 (flush takes priority over accept; the input that cycle is discarded).
//    accept          -> 1
//    out_ready       -> 0
//    otherwise       -> hold
//  Decode. sext() is to XLEN from inst[31]; zext() is zero-extension.
//    inst[1:0]!=2'b11                      -> ILLEGAL
//    0110011 OP                            -> R, imm 0
//    0111011 OP-32                         -> R when XLEN=64, else ILLEGAL
//    0000011/0010011/1100111/0001111       -> I, sext(inst[31:20])
//    0011011 OP-IMM-32                     -> I when XLEN=64, else ILLEGAL
//    0100011                               -> S, sext({inst[31:25],inst[11:7]})
//    1100011                               -> B, sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0})
//    0110111 LUI, 0010111 AUIPC            -> U, sext({inst[31:12],12'b0})
//    1101111                               -> J, sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0})
//    1110011 SYSTEM                        -> SYS; funct3[2]=1 gives zext(inst[19:15]), else zext(inst[31:20])
//    any other opcode                      -> ILLEGAL, imm 0, target 0
//  target_out = (pc + imm) mod 2^XLEN for B, J and AUIPC only; 0 for LUI and every other format.
//  illegal_cnt increments on accept of an ILLEGAL word and saturates at 2^CNT_W-1. Flushed inputs are not counted.
//  Reset mid-stall: the held output is lost, out_valid=0 on the next cycle.
// TESTING
//  1 XLEN=32, inst 0xFFF00093 (addi x1,x0,-1), pc 0x0, out_ready=1
//      -> next cycle: out_valid=1, imm_out 0xFFFFFFFF, fmt 1, target 0.
//  2 inst 0xFE000EE3 (beq -4), pc 0x100
//      -> imm 0xFFFFFFFC, target 0x000000FC, fmt 3.
//  3 inst 0x00001097 (auipc x1,1), pc 0xFFFFF000
//      -> imm 0x00001000, target 0x00000000 (wrap), fmt 4.
//     inst 0x123452B7 (lui)
//      -> imm 0x12345000, target 0.
//  4 XLEN=64, inst 0x800002B7
//      -> imm 0xFFFFFFFF80000000.
//     inst 0x0010009B (addiw)
//      -> fmt 1, imm 1.
//     Same word with XLEN=32
//      -> fmt 7.
//  5 out_ready=0 for 3 cycles while A is held and B is offered
//      -> outputs stay A, in_ready=0.
//     out_ready=1
//      -> B is accepted that cycle; A then B each observed exactly once.
//  6 CNT_W=2, four accepted 0x00000000 words
//      -> illegal_out=1, illegal_cnt 1,2,3,3.
//     flush together with in_valid
//      -> out_valid 0 next cycle, cnt unchanged.

Source files
------------

// File: rtl/imm_gen_stage.sv
// Registered RV32I/RV64I immediate-generation stage: extracts the immediate, PC-relative
// target and instruction format, with valid/ready handshake, flush and illegal counter.
module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst_code,
  input  logic [XLEN-1:0]  pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic [XLEN-1:0]  target_out,
  output logic [2:0]       fmt_out,
  output logic             illegal_out,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_SYS = 3'd6,
    FMT_ILL = 3'd7
  } fmt_e;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_stage: XLEN must be 32 or 64");
    end
  endgenerate

  fmt_e            fmt_d;
  logic [XLEN-1:0] imm_d;
  logic [XLEN-1:0] target_d;
  logic            pcrel_d;
  logic            accept;

  always_comb begin
    // NOTE: every decode output gets a default first, so no path can infer a latch.
    fmt_d   = FMT_ILL;
    imm_d   = '0;
    pcrel_d = 1'b0;
    if (inst_code[1:0] == 2'b11) begin
      case (inst_code[6:0])
        OPC_OP: fmt_d = FMT_R;
        OPC_OP32: if (XLEN == 64) fmt_d = FMT_R;
        OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM: begin
          fmt_d = FMT_I;
          imm_d = XLEN'($signed(inst_code[31:20]));
        end
        OPC_OP_IMM32: if (XLEN == 64) begin
          fmt_d = FMT_I;
          imm_d = XLEN'($signed(inst_code[31:20]));
        end
        OPC_STORE: begin
          fmt_d = FMT_S;
          imm_d = XLEN'($signed({inst_code[31:25], inst_code[11:7]}));
        end
        OPC_BRANCH: begin
          fmt_d   = FMT_B;
          pcrel_d = 1'b1;
          imm_d   = XLEN'($signed({inst_code[31], inst_code[7], inst_code[30:25],
                                   inst_code[11:8], 1'b0}));
        end
        OPC_LUI, OPC_AUIPC: begin
          fmt_d   = FMT_U;
          pcrel_d = (inst_code[6:0] == OPC_AUIPC);
          imm_d   = XLEN'($signed({inst_code[31:12], 12'b0}));
        end
        OPC_JAL: begin
          fmt_d   = FMT_J;
          pcrel_d = 1'b1;
          imm_d   = XLEN'($signed({inst_code[31], inst_code[19:12], inst_code[20],
                                   inst_code[30:21], 1'b0}));
        end
        // CSR immediate forms carry a 5-bit uimm in the rs1 field; others expose the CSR number.
        OPC_SYSTEM: begin
          fmt_d = FMT_SYS;
          imm_d = inst_code[14] ? XLEN'(inst_code[19:15]) : XLEN'(inst_code[31:20]);
        end
        default: ;
      endcase
    end
    target_d = pcrel_d ? (pc + imm_d) : '0;
  end

  assign in_ready = !out_valid | out_ready | flush;
  assign accept   = in_valid & in_ready & !flush;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    if (reset) begin
      out_valid   <= 1'b0;
      imm_out     <= '0;
      target_out  <= '0;
      fmt_out     <= 3'd0;
      illegal_out <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      // Flush wins over a same-cycle accept; the offered word is dropped.
      if (flush)          out_valid <= 1'b0;
      else if (accept)    out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;

      if (accept) begin
        imm_out     <= imm_d;
        target_out  <= target_d;
        fmt_out     <= fmt_d;
        illegal_out <= (fmt_d == FMT_ILL);
        if (fmt_d == FMT_ILL && illegal_cnt != '1)
          illegal_cnt <= illegal_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: three instances (XLEN=32, XLEN=64, XLEN=32 with 2-bit counter)
// driven by the same stimulus and checked against hand vectors and a behavioural model.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, in_valid, out_ready;
  logic [31:0] inst_code;
  logic [63:0] pc;

  logic        a_in_ready, a_out_valid, a_ill;
  logic [31:0] a_imm, a_tgt;
  logic [2:0]  a_fmt;
  logic [15:0] a_cnt;

  logic        b_in_ready, b_out_valid, b_ill;
  logic [63:0] b_imm, b_tgt;
  logic [2:0]  b_fmt;
  logic [15:0] b_cnt;

  logic        c_in_ready, c_out_valid, c_ill;
  logic [31:0] c_imm, c_tgt;
  logic [2:0]  c_fmt;
  logic [1:0]  c_cnt;

  imm_gen_stage #(.XLEN(32), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .inst_code(inst_code), .pc(pc[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
    .imm_out(a_imm), .target_out(a_tgt), .fmt_out(a_fmt), .illegal_out(a_ill),
    .illegal_cnt(a_cnt));

  imm_gen_stage #(.XLEN(64), .CNT_W(16)) u_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .inst_code(inst_code), .pc(pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .imm_out(b_imm), .target_out(b_tgt), .fmt_out(b_fmt), .illegal_out(b_ill),
    .illegal_cnt(b_cnt));

  imm_gen_stage #(.XLEN(32), .CNT_W(2)) u_c (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .inst_code(inst_code), .pc(pc[31:0]), .out_valid(c_out_valid), .out_ready(out_ready),
    .imm_out(c_imm), .target_out(c_tgt), .fmt_out(c_fmt), .illegal_out(c_ill),
    .illegal_cnt(c_cnt));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] imm;
    logic [63:0] tgt;
    logic [2:0]  fmt;
  } mres_t;

  logic        m_valid;
  mres_t       m32, m64;
  int          m_cnt32, m_cnt64, m_cnt2;
  logic [63:0] seen[$];

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [31:0] imm32;
    logic [31:0] tgt32;
    logic [2:0]  fmt32;
    logic [63:0] imm64;
    logic [63:0] tgt64;
    logic [2:0]  fmt64;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic longint sx(input longint val, input int bits);
    longint half;
    half = longint'(1) <<< (bits - 1);
    return (val >= half) ? val - (half <<< 1) : val;
  endfunction

  // Reference decode written from the format rules with plain integer arithmetic.
  function automatic mres_t ref_decode(input logic [31:0] i, input logic [63:0] p, input int xlen);
    mres_t       r;
    longint      v;
    bit          rel;
    logic [63:0] mask;
    v     = 0;
    rel   = 0;
    r.fmt = 3'd7;
    mask  = (xlen == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    if (i[1:0] == 2'b11) begin
      case (i[6:0])
        7'h33: r.fmt = 3'd0;
        7'h3B: if (xlen == 64) r.fmt = 3'd0;
        7'h03, 7'h13, 7'h67, 7'h0F: begin r.fmt = 3'd1; v = sx(longint'(i[31:20]), 12); end
        7'h1B: if (xlen == 64) begin r.fmt = 3'd1; v = sx(longint'(i[31:20]), 12); end
        7'h23: begin
          r.fmt = 3'd2;
          v = sx(longint'(i[31:25]) * 32 + longint'(i[11:7]), 12);
        end
        7'h63: begin
          r.fmt = 3'd3; rel = 1;
          v = sx(longint'(i[31]) * 4096 + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32
                 + longint'(i[11:8]) * 2, 13);
        end
        7'h37: begin r.fmt = 3'd4; v = sx(longint'(i[31:12]) * 4096, 32); end
        7'h17: begin r.fmt = 3'd4; rel = 1; v = sx(longint'(i[31:12]) * 4096, 32); end
        7'h6F: begin
          r.fmt = 3'd5; rel = 1;
          v = sx(longint'(i[31]) * 1048576 + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048
                 + longint'(i[30:21]) * 2, 21);
        end
        7'h73: begin r.fmt = 3'd6; v = i[14] ? longint'(i[19:15]) : longint'(i[31:20]); end
        default: ;
      endcase
    end
    r.imm = 64'(v) & mask;
    r.tgt = rel ? ((p + 64'(v)) & mask) : 64'd0;
    return r;
  endfunction

  task automatic check_outputs();
    check("a_valid", a_out_valid, m_valid);
    check("a_imm",   a_imm, m32.imm);
    check("a_tgt",   a_tgt, m32.tgt);
    check("a_fmt",   a_fmt, m32.fmt);
    check("a_ill",   a_ill, m32.fmt == 3'd7);
    check("a_cnt",   a_cnt, m_cnt32);
    check("b_valid", b_out_valid, m_valid);
    check("b_imm",   b_imm, m64.imm);
    check("b_tgt",   b_tgt, m64.tgt);
    check("b_fmt",   b_fmt, m64.fmt);
    check("b_ill",   b_ill, m64.fmt == 3'd7);
    check("b_cnt",   b_cnt, m_cnt64);
    check("c_valid", c_out_valid, m_valid);
    check("c_imm",   c_imm, m32.imm);
    check("c_fmt",   c_fmt, m32.fmt);
    check("c_cnt",   c_cnt, m_cnt2);
  endtask

  // One clock: drive at posedge+1, check in_ready before the edge, update model, check after.
  task automatic cycle(input logic rst, input logic v, input logic [31:0] i,
                       input logic [63:0] p, input logic ordy, input logic fl);
    logic rdy, acc;
    reset = rst; in_valid = v; inst_code = i; pc = p; out_ready = ordy; flush = fl;
    #3;
    rdy = !m_valid | ordy | fl;
    if (!rst) begin
      check("a_in_ready", a_in_ready, rdy);
      check("b_in_ready", b_in_ready, rdy);
      check("c_in_ready", c_in_ready, rdy);
      if (a_out_valid === 1'b1 && ordy) seen.push_back({32'd0, a_imm});
    end
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
      m32 = '{imm: 64'd0, tgt: 64'd0, fmt: 3'd0};
      m64 = m32;
      m_cnt32 = 0; m_cnt64 = 0; m_cnt2 = 0;
    end else begin
      acc = v & rdy & !fl;
      if (acc) begin
        m32 = ref_decode(i, {32'd0, p[31:0]}, 32);
        m64 = ref_decode(i, p, 64);
        if (m32.fmt == 3'd7) begin
          if (m_cnt32 < 65535) m_cnt32++;
          if (m_cnt2 < 3) m_cnt2++;
        end
        if (m64.fmt == 3'd7 && m_cnt64 < 65535) m_cnt64++;
      end
      if (fl)        m_valid = 1'b0;
      else if (acc)  m_valid = 1'b1;
      else if (ordy) m_valid = 1'b0;
    end
    #1;
    check_outputs();
  endtask

  logic [6:0] opcodes [14] = '{7'h33, 7'h3B, 7'h03, 7'h13, 7'h67, 7'h0F, 7'h1B,
                               7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h7F};

  initial begin
    m_valid = 1'b0;
    m_cnt32 = 0; m_cnt64 = 0; m_cnt2 = 0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    inst_code = 32'd0; pc = 64'd0;
    #1;

    vecs.push_back('{32'hFFF00093, 64'h0,        32'hFFFFFFFF, 32'h0,  3'd1, 64'hFFFFFFFF_FFFFFFFF, 64'h0,           3'd1});
    vecs.push_back('{32'hFE000EE3, 64'h100,      32'hFFFFFFFC, 32'hFC, 3'd3, 64'hFFFFFFFF_FFFFFFFC, 64'hFC,          3'd3});
    vecs.push_back('{32'h00001097, 64'hFFFFF000, 32'h1000,     32'h0,  3'd4, 64'h1000,              64'h1_0000_0000, 3'd4});
    vecs.push_back('{32'h123452B7, 64'h40,       32'h12345000, 32'h0,  3'd4, 64'h12345000,          64'h0,           3'd4});
    vecs.push_back('{32'h800002B7, 64'h0,        32'h80000000, 32'h0,  3'd4, 64'hFFFFFFFF_80000000, 64'h0,           3'd4});
    vecs.push_back('{32'h0010009B, 64'h0,        32'h0,        32'h0,  3'd7, 64'h1,                 64'h0,           3'd1});
    vecs.push_back('{32'h0000003B, 64'h0,        32'h0,        32'h0,  3'd7, 64'h0,                 64'h0,           3'd0});
    vecs.push_back('{32'h00000033, 64'h0,        32'h0,        32'h0,  3'd0, 64'h0,                 64'h0,           3'd0});
    vecs.push_back('{32'hFE512C23, 64'h0,        32'hFFFFFFF8, 32'h0,  3'd2, 64'hFFFFFFFF_FFFFFFF8, 64'h0,           3'd2});
    vecs.push_back('{32'h001000EF, 64'h1000,     32'h800,      32'h1800, 3'd5, 64'h800,             64'h1800,        3'd5});
    vecs.push_back('{32'h3002D073, 64'h0,        32'h5,        32'h0,  3'd6, 64'h5,                 64'h0,           3'd6});
    vecs.push_back('{32'hFFF09073, 64'h0,        32'hFFF,      32'h0,  3'd6, 64'hFFF,               64'h0,           3'd6});
    vecs.push_back('{32'h00004501, 64'h0,        32'h0,        32'h0,  3'd7, 64'h0,                 64'h0,           3'd7});

    // Reset state.
    cycle(1'b1, 1'b0, 32'd0, 64'd0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'd0, 64'd0, 1'b0, 1'b0);
    check("reset_valid", a_out_valid, 1'b0);
    check("reset_imm",   b_imm, 64'd0);
    check("reset_cnt",   a_cnt, 16'd0);

    // Hand vectors, streamed with the consumer always ready.
    foreach (vecs[k]) begin
      cycle(1'b0, 1'b1, vecs[k].inst, vecs[k].pc, 1'b1, 1'b0);
      check("vec_valid", a_out_valid, 1'b1);
      check("vec_imm32", a_imm, vecs[k].imm32);
      check("vec_tgt32", a_tgt, vecs[k].tgt32);
      check("vec_fmt32", a_fmt, vecs[k].fmt32);
      check("vec_imm64", b_imm, vecs[k].imm64);
      check("vec_tgt64", b_tgt, vecs[k].tgt64);
      check("vec_fmt64", b_fmt, vecs[k].fmt64);
    end

    // Back-pressure: A held for three cycles while B waits, then both drain exactly once.
    cycle(1'b1, 1'b0, 32'd0, 64'd0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'hFFF00093, 64'd0, 1'b1, 1'b0);
    seen.delete();
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b1, 32'h123452B7, 64'd0, 1'b0, 1'b0);
      check("stall_imm", a_imm, 32'hFFFFFFFF);
      check("stall_in_ready", a_in_ready, 1'b0);
    end
    cycle(1'b0, 1'b1, 32'h123452B7, 64'd0, 1'b1, 1'b0);
    check("release_imm", a_imm, 32'h12345000);
    cycle(1'b0, 1'b0, 32'd0, 64'd0, 1'b1, 1'b0);
    check("drain_valid", a_out_valid, 1'b0);
    check("seen_count", seen.size(), 2);
    if (seen.size() == 2) begin
      check("seen_a", seen[0], 64'hFFFFFFFF);
      check("seen_b", seen[1], 64'h12345000);
    end

    // Saturating counter on the 2-bit instance, then a flushed illegal word.
    cycle(1'b1, 1'b0, 32'd0, 64'd0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b1, 32'h00000000, 64'd0, 1'b1, 1'b0);
      check("sat_ill", c_ill, 1'b1);
      check("sat_cnt2", c_cnt, (k < 3) ? k + 1 : 3);
      check("sat_cnt16", a_cnt, k + 1);
    end
    cycle(1'b0, 1'b1, 32'h00000000, 64'd0, 1'b1, 1'b1);
    check("flush_valid", c_out_valid, 1'b0);
    check("flush_cnt2", c_cnt, 2'd3);
    check("flush_cnt16", a_cnt, 16'd4);

    // Reset while the output is stalled.
    cycle(1'b0, 1'b1, 32'hFE000EE3, 64'h100, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 32'd0, 64'd0, 1'b0, 1'b0);
    check("stall_held", a_out_valid, 1'b1);
    cycle(1'b1, 1'b0, 32'd0, 64'd0, 1'b0, 1'b0);
    check("rst_stall_valid", a_out_valid, 1'b0);
    check("rst_stall_cnt", a_cnt, 16'd0);

    // Randomised traffic against the reference model.
    for (int k = 0; k < 500; k++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(7) != 0) w[6:0] = opcodes[$urandom_range(13)];
      cycle(($urandom_range(99) == 0), ($urandom_range(3) != 0), w,
            {32'($urandom), 32'($urandom)}, ($urandom_range(2) != 0),
            ($urandom_range(9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
